// File: rtl/subleq_pkg.sv
// subleq_pkg: shared types and constants for the SUBLEQ sequencer.
//   state_e          FSM states of subleq_ctrl
//   WORD_W/ADDR_W    data word width / physical memory address width
//   INSTR_STRIDE     words per instruction (A, B, C)
//   HALT_TARGET_DEF  default branch target that halts the machine
//   pc_out_of_range  true when a 3-word fetch at p would run past the memory
`timescale 1ns/1ps
package subleq_pkg;

    localparam int WORD_W       = 64;
    localparam int ADDR_W       = 10;
    localparam int INSTR_STRIDE = 3;

    localparam logic [WORD_W-1:0] HALT_TARGET_DEF = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        READ,
        LOAD,
        WRITE,
        HALTED
    } state_e;

    // Widened by one bit so a PC near 2^64 cannot wrap past the check.
    function automatic logic pc_out_of_range(input logic [WORD_W-1:0] p, input int depth);
        return ({1'b0, p} + 65'd2) >= 65'(depth);
    endfunction

endpackage

// File: rtl/subleq_branch_unit.sv
// subleq_branch_unit: combinational SUBLEQ arithmetic and branch decision.
//   mem_a, mem_b  operands; diff = mem_b - mem_a (two's-complement wrap)
//   c, pc         branch target and current instruction address
//   taken         diff <= 0 (signed)
//   next_pc       taken ? c : pc + 3
//   halt_req      taken branch to HALT_TARGET
`timescale 1ns/1ps
module subleq_branch_unit
    import subleq_pkg::*;
#(
    parameter logic [WORD_W-1:0] HALT_TARGET = HALT_TARGET_DEF
) (
    input  logic [WORD_W-1:0] mem_a,
    input  logic [WORD_W-1:0] mem_b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] diff,
    output logic              taken,
    output logic [WORD_W-1:0] next_pc,
    output logic              halt_req
);

    assign diff     = mem_b - mem_a;
    assign taken    = ($signed(diff) <= 0);
    assign next_pc  = taken ? c : pc + WORD_W'(INSTR_STRIDE);
    assign halt_req = taken && (c == HALT_TARGET);

endmodule

// File: rtl/subleq_ctrl.sv
// subleq_ctrl: SUBLEQ instruction sequencer. Owns the architectural PC and the
// instruction counter, and drives the unified memory through a fixed 5-cycle
// FETCH/DECODE/READ/LOAD/WRITE loop.
//   clk, rst                  clock, async active-high reset
//   start                     begin execution at START_PC (from IDLE/HALTED)
//   data_out_a/b/c            fetched instruction words A, B, C
//   data_out_mem_a/b          mem[addr_a], mem[addr_b]
//   pc, addr_a, addr_b        memory addresses
//   data_in                   write data mem[B] - mem[A]
//   read_en_abc/a/b, write_en_b  memory strobes (Moore decodes of state)
//   busy, halted, pc_error    status
//   instr_count               instructions completed since last start
`timescale 1ns/1ps
module subleq_ctrl
    import subleq_pkg::*;
#(
    parameter logic [WORD_W-1:0] START_PC    = '0,
    parameter int                MEM_DEPTH   = 1024,
    parameter logic [WORD_W-1:0] HALT_TARGET = HALT_TARGET_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] data_out_a,
    input  logic [WORD_W-1:0] data_out_b,
    input  logic [WORD_W-1:0] data_out_c,
    input  logic [WORD_W-1:0] data_out_mem_a,
    input  logic [WORD_W-1:0] data_out_mem_b,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] addr_a,
    output logic [WORD_W-1:0] addr_b,
    output logic [WORD_W-1:0] data_in,
    output logic              read_en_abc,
    output logic              read_en_a,
    output logic              read_en_b,
    output logic              write_en_b,
    output logic              busy,
    output logic              halted,
    output logic              pc_error,
    output logic [31:0]       instr_count
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] addr_a_q, addr_a_d;
    logic [WORD_W-1:0] addr_b_q, addr_b_d;
    logic [WORD_W-1:0] c_q, c_d;
    logic [WORD_W-1:0] data_in_q, data_in_d;
    logic              pc_error_q, pc_error_d;
    logic [31:0]       count_q, count_d;

    logic [WORD_W-1:0] op_a, op_b;
    logic [WORD_W-1:0] bu_diff, bu_next_pc;
    logic              bu_taken, bu_halt_req;

    // One branch unit serves both LOAD and WRITE. In LOAD it subtracts the
    // memory operands; in WRITE it is fed (0, data_in_q) so diff equals the
    // registered result and taken/next_pc are derived from what was written.
    assign op_a = (state_q == LOAD) ? data_out_mem_a : '0;
    assign op_b = (state_q == LOAD) ? data_out_mem_b : data_in_q;

    subleq_branch_unit #(
        .HALT_TARGET (HALT_TARGET)
    ) u_branch (
        .mem_a    (op_a),
        .mem_b    (op_b),
        .c        (c_q),
        .pc       (pc_q),
        .diff     (bu_diff),
        .taken    (bu_taken),
        .next_pc  (bu_next_pc),
        .halt_req (bu_halt_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= START_PC;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            c_q        <= '0;
            data_in_q  <= '0;
            pc_error_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            c_q        <= c_d;
            data_in_q  <= data_in_d;
            pc_error_q <= pc_error_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        c_d        = c_q;
        data_in_d  = data_in_q;
        pc_error_d = pc_error_q;
        count_d    = count_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_d    = START_PC;
                    count_d = '0;
                    if (pc_out_of_range(START_PC, MEM_DEPTH)) begin
                        pc_error_d = 1'b1;
                        state_d    = HALTED;
                    end else begin
                        pc_error_d = 1'b0;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH:  state_d = DECODE;
            DECODE: begin
                addr_a_d = data_out_a;
                addr_b_d = data_out_b;
                c_d      = data_out_c;
                state_d  = READ;
            end
            READ:   state_d = LOAD;
            LOAD: begin
                data_in_d = bu_diff;
                state_d   = WRITE;
            end
            WRITE: begin
                count_d = count_q + 32'd1;
                if (bu_halt_req) begin
                    state_d = HALTED;
                end else if (pc_out_of_range(bu_next_pc, MEM_DEPTH)) begin
                    pc_error_d = 1'b1;
                    pc_d       = bu_next_pc;
                    state_d    = HALTED;
                end else begin
                    pc_d    = bu_next_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from state_q, so an async reset drops them at once.
    assign read_en_abc = (state_q == FETCH);
    assign read_en_a   = (state_q == READ);
    assign read_en_b   = (state_q == READ);
    assign write_en_b  = (state_q == WRITE);
    assign busy        = (state_q == FETCH) || (state_q == DECODE) || (state_q == READ) ||
                         (state_q == LOAD)  || (state_q == WRITE);
    assign halted      = (state_q == HALTED);

    assign pc          = pc_q;
    assign addr_a      = addr_a_q;
    assign addr_b      = addr_b_q;
    assign data_in     = data_in_q;
    assign pc_error    = pc_error_q;
    assign instr_count = count_q;

endmodule

// File: doc/subleq_ctrl.md
Name: subleq_ctrl

Overview:
Instruction sequencer for the unified SUBLEQ memory (1024 x 64-bit, registered reads with 1-cycle latency, synchronous write to the B address).
- Drives the memory's pc, addr_a, addr_b, data_in and enable strobes.
- Runs each SUBLEQ instruction as fetch A/B/C, read operands, write mem[B] - mem[A], then branch.
- Sits between the top-level start/halt control and the memory block. It also owns the architectural PC and the instruction counter.

Parameters:
- START_PC, 0, PC loaded on reset and on each start pulse.
- MEM_DEPTH, 1024, number of memory words; used for the PC range check.
- HALT_TARGET, 64'hFFFF_FFFF_FFFF_FFFF, branch target that halts the machine when the branch is taken.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from START_PC when in IDLE or HALTED.
- data_out_a  in  64  A operand returned by memory.
- data_out_b  in  64  B operand returned by memory.
- data_out_c  in  64  C operand returned by memory.
- data_out_mem_a  in  64  mem[addr_a] returned by memory.
- data_out_mem_b  in  64  mem[addr_b] returned by memory.
- pc  out  64  instruction fetch address.
- addr_a  out  64  A operand address (latched A).
- addr_b  out  64  B operand address (latched B).
- data_in  out  64  write data, mem[B] - mem[A].
- read_en_abc  out  1  instruction fetch strobe.
- read_en_a  out  1  operand A read strobe.
- read_en_b  out  1  operand B read strobe.
- write_en_b  out  1  write strobe to mem[addr_b].
- busy  out  1  high in FETCH through WRITE.
- halted  out  1  high in HALTED.
- pc_error  out  1  sticky; set when execution stops on an out-of-range PC.
- instr_count  out  32  completed instructions since the last start; wraps modulo 2^32.

Behaviour:
- Reset (async, immediate): state = IDLE; pc = START_PC; addr_a = addr_b = data_in = 0; all strobes = 0; busy = halted = pc_error = 0; instr_count = 0.
- Reset mid-instruction aborts with no further strobes. A write strobe in the reset cycle is deasserted asynchronously.
- Strobes are Moore decodes of the state register, one-hot per state:
  - read_en_abc only in FETCH.
  - read_en_a and read_en_b together only in READ.
  - write_en_b only in WRITE.
- States:
  - IDLE: on start, pc = START_PC, instr_count = 0, pc_error = 0, go to FETCH.
  - FETCH: strobe read_en_abc, go to DECODE.
  - DECODE: memory outputs are valid; latch addr_a = data_out_a, addr_b = data_out_b, c_reg = data_out_c; go to READ.
  - READ: strobe read_en_a and read_en_b, go to LOAD.
  - LOAD: data_in = data_out_mem_b - data_out_mem_a, 64-bit two's-complement wrap; go to WRITE.
  - WRITE: strobe write_en_b. Compute taken = ($signed(data_in) <= 0). Set next_pc = taken ? c_reg : pc + 3. Increment instr_count. Then:
    - taken and c_reg == HALT_TARGET: go to HALTED; pc is left unchanged.
    - else next_pc + 2 >= MEM_DEPTH (unsigned compare): set pc_error, pc = next_pc, go to HALTED.
    - else pc = next_pc, go to FETCH.
  - HALTED: all strobes 0. On start, behave exactly as IDLE on start.
- start is ignored while busy.
- Throughput: 5 cycles per instruction, fixed.
- Self-modifying code: the write lands on the WRITE edge, so a following FETCH of the same word returns the new value. No bypass logic is needed.
- A == B: the result is 0, so the branch is taken and mem[B] is written with 0.
- START_PC out of range is checked at start: go straight to HALTED with pc_error = 1 and issue no fetch.

Decomposition:
- Package subleq_pkg holds:
  - state enum {IDLE, FETCH, DECODE, READ, LOAD, WRITE, HALTED};
  - WORD_W = 64, ADDR_W = 10, INSTR_STRIDE = 3;
  - the HALT_TARGET default.
- One combinational sub-module, subleq_branch_unit: inputs mem_a, mem_b, c, pc; outputs diff, taken, next_pc, halt_req. The FSM stays in subleq_ctrl.

Test Plan:
- Reset mid-WRITE (rst asserted between edges) -> write_en_b falls immediately; state IDLE, pc = 0, instr_count = 0; no strobes until start.
- mem = {3,4,6, 7,7,HALT..} at 0..5, mem[3] = 5, mem[4] = 2, start -> mem[4] = 0xFFFF_FFFF_FFFF_FFFD (2 - 5), taken, pc = 6.
- Same program with mem[3] = 1, mem[4] = 9 -> mem[4] = 8, not taken, pc = 3; strobe sequence abc, a+b, wb in cycles 1, 3, 5.
- Instruction {7,7,HALT_TARGET} at pc 0 -> mem[7] = 0, halted = 1, pc_error = 0, instr_count = 1, busy = 0.
- Branch to C = 1022 -> pc_error = 1, halted, pc = 1022, no FETCH strobe after WRITE.
- Instruction at 0 writes mem[3]; the instruction at 3 executes the modified word -> the fetched operands equal the newly written value.
- start pulsed during DECODE -> ignored; instr_count and pc are unaffected.
